// File: rtl/mem_instr_controller.sv
// Hardwired control unit for the ld/ldi/st subset: sequences fetch and
// execute steps T0..T7, waits on RAM handshakes with a timeout, and counts
// completed instructions.
module mem_instr_controller #(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic               stop,
    input  logic [4:0]         ir_op,
    input  logic               mem_ready,
    output logic               PCout,
    output logic               IncPC,
    output logic               MARin,
    output logic               memRead,
    output logic               memWrite,
    output logic               ramEnable,
    output logic               MDRin,
    output logic               MDRout,
    output logic               IRin,
    output logic               Gra,
    output logic               Grb,
    output logic               Rin,
    output logic               Rout,
    output logic               BAout,
    output logic               Yin,
    output logic               ADD,
    output logic               Cout,
    output logic               Zin,
    output logic               Zlowout,
    output logic               running,
    output logic               halted,
    output logic               fault,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_FAULT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t     state, next_state;
    logic       stop_pending;
    logic [3:0] wait_cnt;
    logic       is_ld, is_ldi, is_st, is_halt;
    logic       in_wait, timeout, complete;

    // Opcode decode and wait-state qualification
    always_comb begin
        is_ld   = (ir_op == OP_LD);
        is_ldi  = (ir_op == OP_LDI);
        is_st   = (ir_op == OP_ST);
        is_halt = (ir_op == OP_HALT);
        in_wait = (state == S_T1) || (state == S_T6 && is_ld) || (state == S_T7 && is_st);
        timeout = in_wait && !mem_ready && (wait_cnt == 4'd7);
    end

    // Next-state and Moore strobe decode
    always_comb begin
        next_state = state;
        complete   = 1'b0;
        PCout = 1'b0; IncPC = 1'b0; MARin = 1'b0; memRead = 1'b0; memWrite = 1'b0;
        ramEnable = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Gra = 1'b0;
        Grb = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0; Yin = 1'b0;
        ADD = 1'b0; Cout = 1'b0; Zin = 1'b0; Zlowout = 1'b0;
        case (state)
            S_IDLE: if (start) next_state = S_T0;
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
                next_state = S_T1;
            end
            S_T1: begin
                memRead = 1'b1; ramEnable = 1'b1; MDRin = 1'b1;
                if (mem_ready)    next_state = S_T2;
                else if (timeout) next_state = S_FAULT;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                next_state = S_T3;
            end
            S_T3: begin
                if (is_ld || is_ldi || is_st) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                    next_state = S_T4;
                end else if (is_halt) begin
                    next_state = S_HALT;
                end else begin
                    next_state = S_FAULT;
                end
            end
            S_T4: begin
                Cout = 1'b1; ADD = 1'b1; Zin = 1'b1;
                next_state = S_T5;
            end
            S_T5: begin
                if (is_ldi) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    complete = 1'b1;
                end else if (is_ld || is_st) begin
                    Zlowout = 1'b1; MARin = 1'b1;
                    next_state = S_T6;
                end else begin
                    next_state = S_FAULT;
                end
            end
            S_T6: begin
                if (is_ld) begin
                    memRead = 1'b1; ramEnable = 1'b1; MDRin = 1'b1;
                    if (mem_ready)    next_state = S_T7;
                    else if (timeout) next_state = S_FAULT;
                end else if (is_st) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                    next_state = S_T7;
                end else begin
                    next_state = S_FAULT;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    complete = 1'b1;
                end else if (is_st) begin
                    memWrite = 1'b1; ramEnable = 1'b1;
                    if (mem_ready)    complete = 1'b1;
                    else if (timeout) next_state = S_FAULT;
                end else begin
                    next_state = S_FAULT;
                end
            end
            S_HALT:  next_state = S_HALT;
            S_FAULT: next_state = S_FAULT;
            default: next_state = S_FAULT;
        endcase
        // A stop seen on the completing edge counts the same as a latched one
        if (complete) next_state = (stop_pending || stop) ? S_IDLE : S_T0;
    end

    // Status flags
    always_comb begin
        running = !(state == S_IDLE || state == S_HALT || state == S_FAULT);
        halted  = (state == S_HALT);
        fault   = (state == S_FAULT);
    end

    // State register
    always_ff @(posedge clock) begin
        if (clear) state <= S_IDLE;
        else       state <= next_state;
    end

    // Stop request latch, dropped on every entry into IDLE
    always_ff @(posedge clock) begin
        if (clear)                          stop_pending <= 1'b0;
        else if (next_state == S_IDLE)      stop_pending <= 1'b0;
        else if (state != S_IDLE && stop)   stop_pending <= 1'b1;
    end

    // Memory wait counter; held at zero outside wait states so every entry starts fresh
    always_ff @(posedge clock) begin
        if (clear)           wait_cnt <= '0;
        else if (!in_wait)   wait_cnt <= '0;
        else if (!mem_ready) wait_cnt <= wait_cnt + 4'd1;
    end

    // Completed-instruction counter, wraps naturally
    always_ff @(posedge clock) begin
        if (clear)         instr_count <= '0;
        else if (complete) instr_count <= instr_count + COUNT_W'(1);
    end

endmodule

// File: doc/mem_instr_controller.md
MEM_INSTR_CONTROLLER -- requirements
Module: mem_instr_controller

Interface
REQ-001 SHALL have one clock and reset synchronous, active-high; ports: clock  in  1  rising-edge clock; clear  in  1  synchronous active-high reset.
REQ-002 SHALL have: start  in  1  leave IDLE and begin fetching.
REQ-003 SHALL have: stop  in  1  request return to IDLE after the current instruction.
REQ-004 SHALL have: ir_op  in  5  IR[31:27], valid from T3 onward.
REQ-005 SHALL have: mem_ready  in  1  RAM access complete this cycle.
REQ-006 SHALL have datapath strobes, out, 1 bit each: PCout, IncPC, MARin, memRead, memWrite, ramEnable, MDRin, MDRout, IRin, Gra, Grb, Rin, Rout, BAout, Yin, ADD, Cout, Zin, Zlowout.
REQ-007 SHALL have: running  out  1  state is neither IDLE, HALT nor FAULT.
REQ-008 SHALL have: halted  out  1  in HALT; fault  out  1  in FAULT (illegal opcode or memory timeout).
REQ-009 SHALL have: instr_count  out  16  completed instructions.

Function
REQ-010 States SHALL be: IDLE, T0..T7, HALT, FAULT; strobes are Moore outputs decoded from state (and ir_op), 0 in IDLE/HALT/FAULT.
REQ-011 IDLE: start=1 -> T0; stop ignored in IDLE.
REQ-012 T0: PCout, MARin, IncPC -> T1.
REQ-013 T1: memRead, ramEnable, MDRin held; mem_ready=1 -> T2, else stay.
REQ-014 T2: MDRout, IRin -> T3.
REQ-015 T3 decode: ld=00000, ldi=00001, st=00010 assert Grb, BAout, Yin -> T4; halt=11011 -> HALT with no strobes; any other op -> FAULT.
REQ-016 T4: Cout, ADD, Zin -> T5.
REQ-017 T5: Zlowout plus ld/st MARin -> T6; ldi Gra, Rin -> instruction complete.
REQ-018 T6: ld memRead, ramEnable, MDRin held until mem_ready=1 -> T7; st Gra, Rout, MDRin -> T7 (one cycle).
REQ-019 T7: ld MDRout, Gra, Rin -> complete (one cycle); st memWrite, ramEnable held until mem_ready=1 -> complete.
REQ-020 On complete: instr_count increments by 1 (wraps FFFF->0000); next state IDLE if stop pending, else T0.
REQ-021 stop SHALL be latched (stop_pending) in any non-IDLE state; cleared on entering IDLE; instruction in progress always finishes.
REQ-022 Wait counter (4 bits) SHALL clear on entry to each wait state (T1, ld T6, st T7), increment each cycle with mem_ready=0; 8th consecutive cycle without mem_ready -> FAULT.
REQ-023 mem_ready outside wait states SHALL be ignored.
REQ-024 HALT and FAULT SHALL be exited only by clear; start ignored there.
REQ-025 ld/ldi/st latency without wait: ldi 6 cycles (T0-T5), ld/st 8 cycles (T0-T7), with mem_ready high on first wait cycle.

Reset
REQ-026 clear=1 at a rising edge SHALL force IDLE, all strobes 0, running=0, halted=0, fault=0, instr_count=0, stop_pending=0, wait counter=0, from any state including mid-wait; clear overrides start.

Verification
REQ-027 clear, start pulse, ir_op=00000, mem_ready=1 -> state sequence T0..T7 then T0, instr_count 0->1 at T7 exit, T5 shows Zlowout+MARin, T7 shows MDRout+Gra+Rin.
REQ-028 ir_op=00001, stop asserted during T2 -> T5 asserts Gra+Rin, next state IDLE, instr_count=1, running=0.
REQ-029 ir_op=00010, mem_ready low 3 cycles in T7 -> memWrite+ramEnable held 4 cycles, then completion, instr_count+1.
REQ-030 mem_ready held 0 in T1 -> FAULT after 8 wait cycles, fault=1, strobes 0; start ignored; clear -> IDLE, fault=0.
REQ-031 ir_op=11011 -> HALT at T3 exit, halted=1; ir_op=10101 -> FAULT; instr_count unchanged in both.
REQ-032 Preload instr_count=FFFF via 65535 ldi completions, one more -> 0000; clear asserted during ld T6 -> IDLE next cycle, memRead=0.
